// File: rtl/frame_sync_ctrl_pkg.sv
// Shared types and defaults for the frame-buffer start-up/resync sequencer.
// The state encoding is fixed because it is exported on the state port.
package frame_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_RUN    = 2'd3
  } fs_state_t;

  localparam int DEF_SETTLE_FRAMES  = 2;
  localparam int DEF_START_LINE     = 20;
  localparam int DEF_TIMEOUT_CYCLES = 1048575;
  localparam int DEF_TIMEOUT_BITS   = 20;

  // Wide enough for the full legal parameter ranges (1..15 frames, 1..4095 lines)
  localparam int FRAME_CNT_BITS = 4;
  localparam int LINE_CNT_BITS  = 12;

  localparam logic [7:0] RESYNC_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RESYNC_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_sync_ctrl.sv
// Start-up and resynchronisation sequencer: releases the frame-buffer read side a
// fixed number of input lines behind the writer and restarts on loss of input.
//
// state  | meaning
// IDLE   | waiting for the first input frame_start
// SETTLE | counting complete input frames before aligning
// ALIGN  | counting input lines after a frame start
// RUN    | reading released; output unblanked from the next frame_start
module frame_sync_ctrl
  import frame_sync_ctrl_pkg::*;
#(
  parameter int SETTLE_FRAMES  = DEF_SETTLE_FRAMES,
  parameter int START_LINE     = DEF_START_LINE,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_BITS   = DEF_TIMEOUT_BITS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       line_doubler,
  input  logic       add_line,
  input  logic       force_resync,
  output logic       starttrigger,
  output logic       video_enable,
  output logic [1:0] state,
  output logic [7:0] resync_count
);

  localparam logic [FRAME_CNT_BITS-1:0] FRAME_TARGET = FRAME_CNT_BITS'(SETTLE_FRAMES);
  localparam logic [LINE_CNT_BITS-1:0]  LINE_TARGET  = LINE_CNT_BITS'(START_LINE);
  localparam logic [TIMEOUT_BITS-1:0]   WD_LAST      = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_BITS-1:0]   WD_MAX       = TIMEOUT_BITS'(TIMEOUT_CYCLES);

  fs_state_t                 state_q, state_d;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_q, frame_cnt_d, frame_nxt;
  logic [LINE_CNT_BITS-1:0]  line_cnt_q, line_cnt_d, line_nxt;
  logic [TIMEOUT_BITS-1:0]   wd_q, wd_d;
  logic                      snap_ld_q, snap_ld_d;
  logic                      snap_al_q, snap_al_d;
  logic                      ve_q, ve_d;
  logic [7:0]                rc_q, rc_d;

  logic active, mode_chg, timeout;

  assign frame_nxt = frame_cnt_q + FRAME_CNT_BITS'(1);
  assign line_nxt  = line_cnt_q + LINE_CNT_BITS'(1);

  assign active   = (state_q != ST_IDLE);
  assign mode_chg = active && ((line_doubler != snap_ld_q) || (add_line != snap_al_q));
  assign timeout  = active && (wd_q == WD_LAST) && !frame_start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      line_cnt_q  <= '0;
      wd_q        <= '0;
      snap_ld_q   <= 1'b0;
      snap_al_q   <= 1'b0;
      ve_q        <= 1'b0;
      rc_q        <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
      wd_q        <= wd_d;
      snap_ld_q   <= snap_ld_d;
      snap_al_q   <= snap_al_d;
      ve_q        <= ve_d;
      rc_q        <= rc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    snap_ld_d   = snap_ld_q;
    snap_al_d   = snap_al_q;
    ve_d        = ve_q;
    rc_d        = rc_q;
    wd_d        = wd_q;

    // Aborts outrank the per-state events; priority order is fixed here.
    if (active && force_resync) begin
      state_d = ST_IDLE;
    end else if (mode_chg) begin
      state_d     = ST_SETTLE;
      frame_cnt_d = '0;
      snap_ld_d   = line_doubler;
      snap_al_d   = add_line;
    end else if (timeout) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_d     = ST_SETTLE;
            frame_cnt_d = '0;
            snap_ld_d   = line_doubler;
            snap_al_d   = add_line;
          end
        end
        ST_SETTLE: begin
          if (frame_start) begin
            frame_cnt_d = frame_nxt;
            if (frame_nxt == FRAME_TARGET) begin
              state_d    = ST_ALIGN;
              line_cnt_d = '0;
            end
          end
        end
        ST_ALIGN: begin
          // A new frame restarts alignment and swallows a coincident line pulse
          if (frame_start) begin
            line_cnt_d = '0;
          end else if (line_start) begin
            line_cnt_d = line_nxt;
            if (line_nxt == LINE_TARGET) state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (frame_start) ve_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != ST_RUN) ve_d = 1'b0;
    if ((state_q == ST_RUN) && (state_d != ST_RUN)) rc_d = sat_inc8(rc_q);

    if ((state_d == ST_IDLE) || frame_start) begin
      wd_d = '0;
    end else if (wd_q != WD_MAX) begin
      wd_d = wd_q + TIMEOUT_BITS'(1);
    end
  end

  assign starttrigger = (state_q == ST_RUN);
  assign video_enable = ve_q;
  assign state        = state_q;
  assign resync_count = rc_q;

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Directed bench for frame_sync_ctrl: vector table for the main sequences plus
// hand-written saturation and mid-operation reset sequences.
module tb_frame_sync_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start, line_start, line_doubler, add_line, force_resync;
  logic       starttrigger, video_enable;
  logic [1:0] state;
  logic [7:0] resync_count;

  int n_pass  = 0;
  int n_total = 0;

  frame_sync_ctrl #(
    .SETTLE_FRAMES (2),
    .START_LINE    (20),
    .TIMEOUT_CYCLES(1000),
    .TIMEOUT_BITS  (20)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .line_doubler(line_doubler),
    .add_line    (add_line),
    .force_resync(force_resync),
    .starttrigger(starttrigger),
    .video_enable(video_enable),
    .state       (state),
    .resync_count(resync_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fs, ls, fr, ld, al;
    int         reps;
    logic [1:0] st;
    logic       trig, ve;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic trig,
                         input logic ve, input logic [7:0] rc);
    chk({tag, " state"}, state, st);
    chk({tag, " starttrigger"}, starttrigger, trig);
    chk({tag, " video_enable"}, video_enable, ve);
    chk({tag, " resync_count"}, resync_count, rc);
  endtask

  task automatic cyc(input logic fs, input logic ls, input logic fr,
                     input logic ld, input logic al);
    @(negedge clock);
    frame_start  = fs;
    line_start   = ls;
    force_resync = fr;
    line_doubler = ld;
    add_line     = al;
    @(posedge clock);
    #1;
    frame_start  = 1'b0;
    line_start   = 1'b0;
    force_resync = 1'b0;
  endtask

  task automatic add(input logic fs, ls, fr, ld, al, input int reps,
                     input logic [1:0] st, input logic trig, ve, input logic [7:0] rc);
    vec_t v;
    v.fs = fs; v.ls = ls; v.fr = fr; v.ld = ld; v.al = al; v.reps = reps;
    v.st = st; v.trig = trig; v.ve = ve; v.rc = rc;
    tbl.push_back(v);
  endtask

  initial begin
    reset        = 1'b1;
    frame_start  = 1'b0;
    line_start   = 1'b0;
    line_doubler = 1'b0;
    add_line     = 1'b0;
    force_resync = 1'b0;

    //  fs ls fr ld al reps  st trig ve rc
    add(0, 0, 0, 0, 0,   3,  0, 0, 0, 0);  // idle after reset
    add(0, 0, 1, 0, 0,   1,  0, 0, 0, 0);  // force_resync ignored in IDLE
    add(1, 0, 0, 0, 0,   1,  1, 0, 0, 0);  // t0
    add(0, 0, 0, 0, 0,   5,  1, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1,  1, 0, 0, 0);  // t1
    add(0, 0, 0, 0, 0,   3,  1, 0, 0, 0);
    add(1, 0, 0, 0, 0,   1,  2, 0, 0, 0);  // t2 -> ALIGN
    add(0, 1, 0, 0, 0,  19,  2, 0, 0, 0);
    add(0, 1, 0, 0, 0,   1,  3, 1, 0, 0);  // 20th line -> RUN
    add(0, 0, 0, 0, 0,   4,  3, 1, 0, 0);  // first partial frame blanked
    add(1, 0, 0, 0, 0,   1,  3, 1, 1, 0);
    add(0, 0, 0, 0, 0,   2,  3, 1, 1, 0);
    add(0, 0, 0, 1, 0,   1,  1, 0, 0, 1);  // line_doubler toggles in RUN
    add(1, 0, 0, 1, 0,   1,  1, 0, 0, 1);
    add(1, 0, 0, 1, 0,   1,  2, 0, 0, 1);
    add(0, 1, 0, 1, 0,  20,  3, 1, 0, 1);
    add(1, 0, 0, 1, 0,   1,  3, 1, 1, 1);
    add(0, 0, 1, 1, 0,   1,  0, 0, 0, 2);  // force_resync in RUN
    add(1, 0, 0, 1, 0,   1,  1, 0, 0, 2);
    add(1, 0, 0, 1, 0,   1,  1, 0, 0, 2);
    add(1, 0, 0, 1, 0,   1,  2, 0, 0, 2);
    add(0, 1, 0, 1, 0,  19,  2, 0, 0, 2);  // line count 19
    add(1, 1, 0, 1, 0,   1,  2, 0, 0, 2);  // frame+line together: count cleared
    add(0, 1, 0, 1, 0,  19,  2, 0, 0, 2);  // back to 19, still ALIGN
    add(1, 0, 1, 1, 0,   1,  0, 0, 0, 2);  // force+frame: IDLE, not a RUN exit
    add(0, 0, 0, 0, 0,   2,  0, 0, 0, 2);  // mode change in IDLE ignored
    add(1, 0, 0, 0, 0,   1,  1, 0, 0, 2);
    add(1, 0, 0, 0, 0,   1,  1, 0, 0, 2);  // frame count 1
    add(1, 0, 0, 0, 1,   1,  1, 0, 0, 2);  // add_line change wins over frame_start
    add(1, 0, 0, 0, 1,   1,  1, 0, 0, 2);
    add(1, 0, 0, 0, 1,   1,  2, 0, 0, 2);
    add(0, 1, 0, 0, 1,  20,  3, 1, 0, 2);
    add(1, 0, 0, 0, 1,   1,  3, 1, 1, 2);  // last frame_start
    add(0, 0, 0, 0, 1, 999,  3, 1, 1, 2);  // one cycle short of the timeout
    add(0, 0, 0, 0, 1,   1,  0, 0, 0, 3);  // timeout exactly 1000 cycles later

    #12;
    chk_all("reset", 2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].reps; k++)
        cyc(tbl[i].fs, tbl[i].ls, tbl[i].fr, tbl[i].ld, tbl[i].al);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].trig, tbl[i].ve, tbl[i].rc);
    end

    // Saturation: 300 RUN exits via force_resync, counter starting at 3
    for (int i = 0; i < 300; i++) begin
      int exp_rc;
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1);
      for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 1);
      if (i == 0 || i == 299) chk("sat run state", state, 3);
      cyc(0, 0, 1, 0, 1);
      exp_rc = (i + 4 > 255) ? 255 : i + 4;
      chk($sformatf("sat%0d resync_count", i), resync_count, exp_rc);
    end
    chk("sat exit state", state, 0);

    // Asynchronous reset between clock edges while in ALIGN
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 1);
    chk("pre-reset state", state, 2);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async reset", 2'd0, 1'b0, 1'b0, 8'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1);
    chk("post-reset idle state", state, 0);
    cyc(1, 0, 0, 0, 1);
    chk_all("post-reset frame", 2'd1, 1'b0, 1'b0, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
